// File: rtl/cache_refill.sv
// cache_refill: AXI4 INCR read burst refill of one cache line.
// Assembles returned beats into an SRAM line and pulses refill_rsp.
module cache_refill #(
  parameter int AXDATA_W       = 32,
  parameter int CACHE_DATA_N   = 4,
  parameter int CACHE_OFFSET_W = 2,
  parameter int CORE_DATA_W    = 32,
  parameter int CACHE_TAG_W    = 20,
  parameter int CACHE_INDEX_W  = 8,
  parameter int AXID_W         = 4,
  parameter int AXADDR_W       = 32,
  parameter int AXLEN_W        = 8,
  parameter int AXSIZE_W       = 3,
  parameter int AXBURST_W      = 2,
  parameter int AXLOCK_W       = 1,
  parameter int AXCACHE_W      = 4,
  parameter int AXPROT_W       = 3,
  parameter int AXQOS_W        = 4,
  parameter int AXREGION_W     = 4,
  parameter int AXRESP_W       = 2,
  parameter int SRAM_DATA_W    = AXDATA_W * CACHE_DATA_N,
  parameter logic [AXID_W-1:0]    RF_ARID    = '0,
  parameter logic [AXSIZE_W-1:0]  RF_ARSIZE  =
    AXSIZE_W'($clog2(AXDATA_W / 8)),
  parameter logic [AXBURST_W-1:0] RF_ARBURST = 2'b01,
  parameter logic [AXLEN_W-1:0]   RF_ARLEN   =
    AXLEN_W'(CACHE_DATA_N - 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     info_rsp,
  input  logic                     info_miss,
  input  logic [CACHE_TAG_W-1:0]   core_tag,
  input  logic [CACHE_INDEX_W-1:0] core_index,
  output logic                     refill_rsp,
  output logic [SRAM_DATA_W-1:0]   refill_data,
  output logic                     refill_err,
  output logic [AXID_W-1:0]        rf_arid,
  output logic [AXADDR_W-1:0]      rf_araddr,
  output logic [AXLEN_W-1:0]       rf_arlen,
  output logic [AXSIZE_W-1:0]      rf_arsize,
  output logic [AXBURST_W-1:0]     rf_arburst,
  output logic [AXLOCK_W-1:0]      rf_arlock,
  output logic [AXCACHE_W-1:0]     rf_arcache,
  output logic [AXPROT_W-1:0]      rf_arport,
  output logic [AXQOS_W-1:0]       rf_arqos,
  output logic [AXREGION_W-1:0]    rf_arregion,
  output logic                     rf_arvalid,
  input  logic                     rf_arready,
  input  logic [AXID_W-1:0]        rf_rid,
  input  logic [AXDATA_W-1:0]      rf_rdata,
  input  logic [AXRESP_W-1:0]      rf_rresp,
  input  logic                     rf_rlast,
  input  logic                     rf_rvalid,
  output logic                     rf_rready
);

  localparam int BYTE_W = $clog2(CORE_DATA_W / 8);
  localparam logic [CACHE_OFFSET_W-1:0] LAST_CNT =
    CACHE_OFFSET_W'(RF_ARLEN);

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R,
    DONE
  } state_t;

  state_t                    state;
  logic [CACHE_OFFSET_W-1:0] count;
  logic                      req;
  logic                      beat_ok;
  logic                      is_last;

  assign rf_arid     = RF_ARID;
  assign rf_arlen    = RF_ARLEN;
  assign rf_arsize   = RF_ARSIZE;
  assign rf_arburst  = RF_ARBURST;
  assign rf_arlock   = '0;
  assign rf_arcache  = '0;
  assign rf_arport   = '0;
  assign rf_arqos    = '0;
  assign rf_arregion = '0;

  assign req     = info_rsp & info_miss;
  assign beat_ok = rf_rvalid & rf_rready & (rf_rid == RF_ARID);
  assign is_last = (count == LAST_CNT);

  // Refill FSM: issue AR, collect beats in order, pulse completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      rf_arvalid  <= 1'b0;
      rf_rready   <= 1'b0;
      refill_rsp  <= 1'b0;
      refill_err  <= 1'b0;
      rf_araddr   <= '0;
      refill_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          refill_rsp <= 1'b0;
          if (req) begin
            rf_araddr  <= AXADDR_W'({core_tag, core_index,
                                     {CACHE_OFFSET_W{1'b0}},
                                     {BYTE_W{1'b0}}});
            rf_arvalid <= 1'b1;
            count      <= '0;
            refill_err <= 1'b0;
            state      <= AR;
          end
        end
        AR: begin
          if (rf_arready) begin
            rf_arvalid <= 1'b0;
            rf_rready  <= 1'b1;
            state      <= R;
          end
        end
        R: begin
          if (beat_ok) begin
            refill_data[int'(count) * AXDATA_W +: AXDATA_W]
              <= rf_rdata;
            count <= count + 1'b1;
            if (rf_rresp != '0) refill_err <= 1'b1;
            if (rf_rlast != is_last) refill_err <= 1'b1;
            if (is_last) begin
              rf_rready  <= 1'b0;
              refill_rsp <= 1'b1;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          refill_rsp <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill.sv
// tb_cache_refill: directed and random refills vs a line model.
// Model builds the line from own-RID beats and flags error rules.
module tb_cache_refill;

  logic         clk = 1'b0;
  logic         reset;
  logic         info_rsp, info_miss;
  logic [19:0]  core_tag;
  logic [7:0]   core_index;
  logic         refill_rsp;
  logic [127:0] refill_data;
  logic         refill_err;
  logic [3:0]   rf_arid;
  logic [31:0]  rf_araddr;
  logic [7:0]   rf_arlen;
  logic [2:0]   rf_arsize;
  logic [1:0]   rf_arburst;
  logic [0:0]   rf_arlock;
  logic [3:0]   rf_arcache;
  logic [2:0]   rf_arport;
  logic [3:0]   rf_arqos;
  logic [3:0]   rf_arregion;
  logic         rf_arvalid, rf_arready;
  logic [3:0]   rf_rid;
  logic [31:0]  rf_rdata;
  logic [1:0]   rf_rresp;
  logic         rf_rlast, rf_rvalid, rf_rready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rsp_pulses = 0;
  int done_cnt = 0;

  typedef struct packed {
    logic [3:0]  rid;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t beats[$];

  cache_refill dut (
    .clk(clk), .reset(reset),
    .info_rsp(info_rsp), .info_miss(info_miss),
    .core_tag(core_tag), .core_index(core_index),
    .refill_rsp(refill_rsp), .refill_data(refill_data),
    .refill_err(refill_err),
    .rf_arid(rf_arid), .rf_araddr(rf_araddr),
    .rf_arlen(rf_arlen), .rf_arsize(rf_arsize),
    .rf_arburst(rf_arburst), .rf_arlock(rf_arlock),
    .rf_arcache(rf_arcache), .rf_arport(rf_arport),
    .rf_arqos(rf_arqos), .rf_arregion(rf_arregion),
    .rf_arvalid(rf_arvalid), .rf_arready(rf_arready),
    .rf_rid(rf_rid), .rf_rdata(rf_rdata),
    .rf_rresp(rf_rresp), .rf_rlast(rf_rlast),
    .rf_rvalid(rf_rvalid), .rf_rready(rf_rready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (refill_rsp === 1'b1) rsp_pulses++;

  task automatic check(input string nm, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", nm, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] rid, input logic [31:0] d,
                      input logic [1:0] resp, input logic last);
    beat_t b;
    b.rid = rid; b.data = d; b.resp = resp; b.last = last;
    beats.push_back(b);
  endtask

  task automatic refill(input string nm, input logic [19:0] tg,
                        input logic [7:0] ix, input int ar_delay,
                        input int gap, input bit busy);
    logic [127:0] exp_line;
    logic [31:0]  exp_addr;
    logic         exp_err;
    int k, req_cyc, nb, exp_lat;
    exp_line = '0; exp_err = 1'b0; k = 0;
    foreach (beats[i]) begin
      if (beats[i].rid == 4'd0) begin
        exp_line[k*32 +: 32] = beats[i].data;
        if (beats[i].resp != 2'b00) exp_err = 1'b1;
        if (beats[i].last != (k == 3)) exp_err = 1'b1;
        k++;
      end
    end
    nb = beats.size();
    exp_lat = 3 + ar_delay + (nb - 1) * (gap + 1);
    exp_addr = {tg, ix, 4'b0000};
    info_rsp = 1; info_miss = 1; core_tag = tg; core_index = ix;
    req_cyc = cyc;
    @(negedge clk);
    info_rsp = 0; info_miss = 0;
    check({nm, ".arvalid"}, rf_arvalid, 1);
    check({nm, ".araddr"}, rf_araddr, exp_addr);
    repeat (ar_delay) begin
      @(negedge clk);
      check({nm, ".arvalid_hold"}, rf_arvalid, 1);
      check({nm, ".araddr_hold"}, rf_araddr, exp_addr);
      check({nm, ".rready_ar"}, rf_rready, 0);
    end
    rf_arready = 1;
    @(negedge clk);
    rf_arready = 0;
    check({nm, ".arvalid_drop"}, rf_arvalid, 0);
    check({nm, ".rready_on"}, rf_rready, 1);
    foreach (beats[i]) begin
      if (i > 0) begin
        repeat (gap) begin
          @(negedge clk);
          check({nm, ".rready_gap"}, rf_rready, 1);
          check({nm, ".arvalid_r"}, rf_arvalid, 0);
        end
      end
      check({nm, ".rready_beat"}, rf_rready, 1);
      rf_rvalid = 1; rf_rid = beats[i].rid;
      rf_rdata = beats[i].data; rf_rresp = beats[i].resp;
      rf_rlast = beats[i].last;
      if (busy && i == 1) begin
        info_rsp = 1; info_miss = 1; core_tag = ~tg;
      end
      @(negedge clk);
      rf_rvalid = 0; rf_rlast = 0; rf_rresp = 0;
      info_rsp = 0; info_miss = 0;
    end
    check({nm, ".rsp"}, refill_rsp, 1);
    check({nm, ".rready_off"}, rf_rready, 0);
    check({nm, ".arvalid_done"}, rf_arvalid, 0);
    check({nm, ".data"}, refill_data, exp_line);
    check({nm, ".err"}, refill_err, exp_err);
    check({nm, ".latency"}, 128'(cyc - req_cyc), 128'(exp_lat));
    done_cnt++;
    @(negedge clk);
    check({nm, ".rsp_pulse"}, refill_rsp, 0);
    check({nm, ".no_second_ar"}, rf_arvalid, 0);
    check({nm, ".data_hold"}, refill_data, exp_line);
  endtask

  initial begin
    reset = 1; info_rsp = 0; info_miss = 0;
    core_tag = '0; core_index = '0;
    rf_arready = 0; rf_rid = '0; rf_rdata = '0;
    rf_rresp = '0; rf_rlast = 0; rf_rvalid = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    check("rst.arvalid", rf_arvalid, 0);
    check("rst.rready", rf_rready, 0);
    check("rst.rsp", refill_rsp, 0);
    check("rst.err", refill_err, 0);
    check("rst.araddr", rf_araddr, 0);
    check("rst.data", refill_data, 0);
    check("const.arlen", rf_arlen, 3);
    check("const.arsize", rf_arsize, 2);
    check("const.arburst", rf_arburst, 1);
    check("const.arid", rf_arid, 0);
    check("const.misc", {rf_arlock, rf_arcache, rf_arport,
                         rf_arqos, rf_arregion}, 0);

    beats.delete();
    push(0, 32'h11111111, 0, 0);
    push(0, 32'h22222222, 0, 0);
    push(0, 32'h33333333, 0, 0);
    push(0, 32'h44444444, 0, 1);
    refill("basic", 20'h12345, 8'h1A, 0, 0, 0);

    beats.delete();
    for (int k = 0; k < 4; k++) push(0, $urandom, 0, k == 3);
    refill("bp", 20'($urandom), 8'($urandom), 5, 2, 0);

    beats.delete();
    for (int k = 0; k < 4; k++)
      push(0, $urandom, (k == 2) ? 2'b10 : 2'b00, k == 3);
    refill("slverr", 20'($urandom), 8'($urandom), 1, 0, 0);

    beats.delete();
    for (int k = 0; k < 4; k++) push(0, $urandom, 0, k == 1);
    refill("early_last", 20'($urandom), 8'($urandom), 0, 1, 0);

    beats.delete();
    push(0, $urandom, 0, 0);
    push(0, $urandom, 0, 0);
    push(4'h5, $urandom, 2'b11, 1);
    push(0, $urandom, 0, 0);
    push(0, $urandom, 0, 1);
    refill("foreign", 20'($urandom), 8'($urandom), 0, 0, 0);

    beats.delete();
    for (int k = 0; k < 4; k++) push(0, $urandom, 0, k == 3);
    refill("busy", 20'($urandom), 8'($urandom), 0, 1, 1);

    info_rsp = 1; info_miss = 1; core_tag = 20'hABCDE;
    core_index = 8'h33;
    @(negedge clk);
    info_rsp = 0; info_miss = 0;
    check("mid.arvalid", rf_arvalid, 1);
    rf_arready = 1;
    @(negedge clk);
    rf_arready = 0;
    rf_rvalid = 1; rf_rid = 0; rf_rdata = 32'hDEADBEEF;
    rf_rresp = 2'b10; rf_rlast = 0;
    @(negedge clk);
    rf_rvalid = 0; rf_rresp = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("mid.rready", rf_rready, 0);
    check("mid.arvalid_rst", rf_arvalid, 0);
    check("mid.rsp", refill_rsp, 0);
    check("mid.err", refill_err, 0);
    check("mid.data", refill_data, 0);
    beats.delete();
    for (int k = 0; k < 4; k++) push(0, $urandom, 0, k == 3);
    refill("after_rst", 20'($urandom), 8'($urandom), 0, 0, 0);

    for (int t = 0; t < 25; t++) begin
      beats.delete();
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 3) == 0)
          push(4'($urandom_range(1, 15)), $urandom,
               2'($urandom), 1'($urandom));
        push(0, $urandom,
             ($urandom_range(0, 5) == 0) ?
               2'($urandom_range(1, 3)) : 2'b00,
             ($urandom_range(0, 7) == 0) ? (k != 3) : (k == 3));
      end
      refill($sformatf("rnd%0d", t), 20'($urandom), 8'($urandom),
             $urandom_range(0, 4), $urandom_range(0, 2),
             1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk);
    check("rsp_count", 128'(rsp_pulses), 128'(done_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
